// File: rtl/rom_burst_reader.sv
// Burst read sequencer for a registered-output ROM: walks a wrapping address range,
// one ROM enable per word, and hands each word to a consumer over valid/ready.
module rom_burst_reader #(
  parameter int AW = 3,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] rom_addr,
  output logic          rom_en,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    LAT,
    OUT
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] addr_q;
  logic [AW:0]   remaining_q;
  logic [DW-1:0] data_q;
  logic          valid_q;
  logic          done_q;
  logic          handshake;
  logic          last_word;

  assign handshake = (state == OUT) && valid_q && out_ready;
  assign last_word = (remaining_q == (AW+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && (length != '0)) state_next = REQ;
      REQ:  state_next = LAT;
      LAT:  state_next = OUT;
      OUT:  if (handshake) state_next = last_word ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  // done is registered so it lands in the IDLE cycle after the completing event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr_q      <= base_addr;
              remaining_q <= length;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        LAT: begin
          data_q  <= rom_data;
          valid_q <= 1'b1;
        end
        OUT: begin
          if (handshake) begin
            valid_q <= 1'b0;
            if (last_word) begin
              done_q <= 1'b1;
            end else begin
              addr_q      <= addr_q + AW'(1);
              remaining_q <= remaining_q - (AW+1)'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign rom_en    = (state == REQ);
  assign rom_addr  = addr_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Burst read sequencer sitting directly upstream of the 8-entry registered-output ROM. On a `start` command it walks a contiguous, wrapping address range. For each word it pulses the ROM enable, absorbs the ROM's one-cycle read latency, and presents each word to a downstream consumer over a valid/ready handshake. It is the only master of the ROM's address and enable lines.

## Interface
- `AW`, default 3: ROM address width (ROM depth 2^AW).
- `DW`, default 8: ROM data width.
- `clk`  input  1  rising-edge clock, shared with the ROM.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  burst request; sampled only in IDLE.
- `base_addr`  input  AW  first address of burst; sampled with `start`.
- `length`  input  AW+1  number of words, 0..2^AW; sampled with `start`.
- `busy`  output  1  high whenever state is not IDLE.
- `done`  output  1  one-cycle pulse when a burst completes.
- `rom_addr`  output  AW  address to ROM.
- `rom_en`  output  1  ROM read enable.
- `rom_data`  input  DW  ROM registered read data.
- `out_data`  output  DW  word to consumer.
- `out_valid`  output  1  `out_data` valid.
- `out_ready`  input  1  consumer accepts word.

## Operation
- Reset values: state IDLE; `busy`=0, `done`=0, `rom_en`=0, `rom_addr`=0, `out_data`=0, `out_valid`=0; internal address and remaining count = 0.
- States: IDLE, REQ, LAT, OUT.
- IDLE:
  - `start`=1 with `length`≠0: latch `base_addr` into the address register and `length` into the remaining count, then go to REQ.
  - `start`=1 with `length`=0: stay in IDLE and pulse `done` next cycle; no ROM access.
- REQ: `rom_en`=1 for exactly one cycle. `rom_addr` = address register, and holds that value until it is next updated. Unconditionally go to LAT.
- LAT: `rom_en`=0. At the end of the cycle, capture `rom_data` into `out_data` and set `out_valid`=1. Go to OUT.
- OUT: hold `out_data` and `out_valid` stable until `out_valid && out_ready`. On the handshake:
  - `out_valid` is cleared at that edge.
  - If remaining = 1: go to IDLE and pulse `done` the next cycle.
  - Otherwise: address ← (address + 1) mod 2^AW, remaining ← remaining − 1, go to REQ.
- `rom_en` is asserted only in REQ: exactly one enable per word, never while waiting on backpressure.
- Address arithmetic is AW bits wide and wraps silently from 2^AW−1 to 0. The count uses AW+1 bits, so `length`=2^AW reads every entry once.
- `start` while `busy`=1 is ignored. It is neither queued nor allowed to alter the current burst.
- `base_addr` and `length` are ignored outside the start cycle.
- `rst_n` low at any time forces all reset values immediately and abandons the burst. No `done` is produced for an abandoned burst. A word held in OUT is discarded.
- `done` and `busy` are mutually exclusive. `done` is high only in the IDLE cycle following the completing event.

## Timing
- Cycle 0: `start` sampled. Cycle 1: REQ (`rom_en`=1). Cycle 2: LAT (`rom_data` valid). Cycle 3: OUT, first `out_valid`=1.
- With `out_ready` held 1, word n appears in cycle 3+3n, giving a throughput of one word per 3 cycles.
- A burst of L words with no backpressure:
  - last handshake in cycle 3L;
  - `done`=1 and `busy`=0 in cycle 3L+1.
- Each cycle of `out_ready`=0 in OUT adds exactly one cycle of latency.
- A `start` in the `done` cycle is accepted, since the block is IDLE.
- Zero-length burst: `start` in cycle 0 gives `done`=1 in cycle 1; `busy` stays 0 throughout.

## Test plan
ROM contents are entry[a] = a+1 for all scenarios below.
- Full sweep: `base_addr`=0, `length`=8, `out_ready`=1.
  - `out_data` = 1,2,…,8 in cycles 3,6,…,24.
  - `rom_addr` sequence 0..7.
  - `done` in cycle 25; exactly 8 `rom_en` pulses.
- Wrap: `base_addr`=6, `length`=4.
  - `rom_addr` = 6,7,0,1; `out_data` = 7,8,1,2; `done` after the 4th handshake.
- Backpressure: `base_addr`=2, `length`=2, `out_ready`=0 for cycles 3–7 and 1 from cycle 8.
  - `out_data`=3 held stable with `out_valid`=1 through cycle 8; no `rom_en` in cycles 3–8.
  - Second word 4 appears in cycle 11.
- Zero length and ignored start:
  - `length`=0 gives `done` in cycle 1 with no `rom_en`.
  - During a `length`=3 burst, `start` with `base_addr`=5 is ignored; the output stays 1,2,3 from `base_addr`=0.
- Reset mid-burst: assert `rst_n`=0 while in OUT of word 2.
  - `out_valid`, `busy`, and `rom_en` drop immediately; no `done`.
  - A new burst after release starts cleanly at its own `base_addr`.
